pl_ex_mem: RTL and testbench
============================

PL_EX_MEM -- requirements
Module: pl_ex_mem

Interface
REQ-001 SHALL have parameter WORD_W, default 32, datapath width in bits.
REQ-002 SHALL have port CLK  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have port nRST  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port WEN  in  1  pipeline advance enable from the hazard unit.
REQ-005 SHALL have port flush  in  1  squash the stage contents on the next advance.
REQ-006 SHALL have ports aluout_in, rtdata_in, npc_in  in  WORD_W each  EX results.
REQ-007 SHALL have ports wsel_in  in  5, regwen_in, memren_in, memwen_in, halt_in  in  1 each  EX control.
REQ-008 SHALL have ports dmemREN, dmemWEN  out  1; dmemaddr, dmemstore  out  WORD_W  data memory request.
REQ-009 SHALL have ports dhit  in  1; dmemload_in  in  WORD_W  data memory response.
REQ-010 SHALL have port mem_busy  out  1  stall request to the hazard unit.
REQ-011 SHALL have ports dmemload_out, dmemaddr_out, npc_out  out  WORD_W; wsel_out  out  5; regwen_out, halt_out, align_fault  out  1  feed to MEM/WB.

Function
REQ-012 SHALL implement FSM states IDLE, REQ, DONE.
REQ-013 SHALL capture all *_in fields into stage registers on a rising edge with WEN=1 and mem_busy=0.
REQ-014 SHALL, when flush=1 at a capture edge, load a bubble: regwen, memren, memwen, halt all 0; data fields 0.
REQ-015 SHALL move IDLE/DONE -> REQ at a capture edge whose captured memren or memwen is 1; otherwise to IDLE.
REQ-016 SHALL drive dmemREN/dmemWEN from the registered memren/memwen only in REQ; 0 in IDLE and DONE.
REQ-017 SHALL drive dmemaddr = registered aluout, dmemstore = registered rtdata, continuously.
REQ-018 SHALL drive mem_busy = (state==REQ) && !dhit, combinationally.
REQ-019 SHALL, in REQ with dhit=1, latch dmemload_in into the load register (reads only) and move to DONE at that edge.
REQ-020 SHALL hold REQ and all stage registers while dhit=0, regardless of WEN and flush.
REQ-021 SHALL ignore WEN=1 while mem_busy=1; a flush asserted during REQ takes effect at the first capture edge after REQ exits.
REQ-022 SHALL set halt_out when a non-bubble halt is captured; halt_out sticky until reset.
REQ-023 SHALL, once halt_out=1, block all further captures and memory requests.
REQ-024 SHALL pass registered aluout on dmemaddr_out, and npc, wsel, regwen on the matching outputs.
REQ-025 SHALL give single-cycle memory latency: request cycle = cycle after capture; a same-cycle dhit frees the pipeline without a stall.

Reset
REQ-026 SHALL, on nRST=0, force state IDLE and all registers and outputs to 0 immediately: mem_busy=0, dmemREN=0, dmemWEN=0, halt_out=0, align_fault=0.
REQ-027 SHALL abandon an in-flight request on reset mid-REQ; no request is reissued after release.

Configuration
REQ-028 SHALL, with macro PL_EX_MEM_ALIGN_CHECK_EN defined, treat a capture with memren|memwen and aluout_in[1:0]!=0 as a fault: no REQ entry, align_fault=1 for that stage occupancy, regwen_out forced 0.
REQ-029 SHALL, without PL_EX_MEM_ALIGN_CHECK_EN, tie align_fault to 0 and issue the request with the address unmodified.

Verification
REQ-030 SHALL cover a load: capture memren=1, aluout=0x0000_0100; dhit=0 for 2 cycles, then 1 with dmemload_in=0xDEAD_BEEF -> mem_busy high 2 cycles, dmemload_out=0xDEAD_BEEF, state DONE.
REQ-031 SHALL cover a store: memwen=1, aluout=0x200, rtdata=0x1234 with same-cycle dhit -> dmemWEN pulse 1 cycle, dmemstore=0x1234, mem_busy never 1.
REQ-032 SHALL cover a flush during REQ: flush=1 while dhit=0 -> request holds until dhit; next capture with flush=1 yields a bubble (regwen_out=0).
REQ-033 SHALL cover halt: capture halt_in=1 -> halt_out=1 next cycle; later WEN=1 with memren=1 produces no dmemREN.
REQ-034 SHALL cover reset mid-REQ: nRST low while dmemREN=1 -> dmemREN=0 asynchronously, state IDLE after release.
REQ-035 SHALL cover, with PL_EX_MEM_ALIGN_CHECK_EN, a load to 0x102 -> align_fault=1, dmemREN=0, regwen_out=0.

Source files
------------

// File: rtl/pl_ex_mem.sv
// EX/MEM pipeline register with a single-outstanding data-memory request FSM.
// Optional misaligned-access trap: define PL_EX_MEM_ALIGN_CHECK_EN.
module pl_ex_mem #(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              WEN,
    input  logic              flush,
    input  logic [WORD_W-1:0] aluout_in,
    input  logic [WORD_W-1:0] rtdata_in,
    input  logic [WORD_W-1:0] npc_in,
    input  logic [4:0]        wsel_in,
    input  logic              regwen_in,
    input  logic              memren_in,
    input  logic              memwen_in,
    input  logic              halt_in,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload_in,
    output logic              mem_busy,
    output logic [WORD_W-1:0] dmemload_out,
    output logic [WORD_W-1:0] dmemaddr_out,
    output logic [WORD_W-1:0] npc_out,
    output logic [4:0]        wsel_out,
    output logic              regwen_out,
    output logic              halt_out,
    output logic              align_fault
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

    state_t            state;
    logic [WORD_W-1:0] aluout_p0;
    logic [WORD_W-1:0] rtdata_p0;
    logic [WORD_W-1:0] npc_p0;
    logic [WORD_W-1:0] load_p0;
    logic [4:0]        wsel_p0;
    logic              regwen_p0;
    logic              memren_p0;
    logic              memwen_p0;
    logic              halt_p0;
    logic              fault_p0;

    logic              capture;
    logic              misalign;
    logic              go_req;

    assign mem_busy = (state == REQ) && !dhit;
    // A halted pipeline never accepts another instruction.
    assign capture  = WEN && !mem_busy && !halt_out;

`ifdef PL_EX_MEM_ALIGN_CHECK_EN
    assign misalign = !flush && (memren_in || memwen_in) && (aluout_in[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign go_req = !flush && (memren_in || memwen_in) && !halt_in && !misalign;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            aluout_p0 <= '0;
            rtdata_p0 <= '0;
            npc_p0    <= '0;
            load_p0   <= '0;
            wsel_p0   <= '0;
            regwen_p0 <= 1'b0;
            memren_p0 <= 1'b0;
            memwen_p0 <= 1'b0;
            halt_p0   <= 1'b0;
            fault_p0  <= 1'b0;
        end else begin
            if ((state == REQ) && dhit) begin
                if (memren_p0)
                    load_p0 <= dmemload_in;
                state <= DONE;
            end
            // A capture on the hit edge starts the next occupancy immediately.
            if (capture) begin
                if (flush) begin
                    aluout_p0 <= '0;
                    rtdata_p0 <= '0;
                    npc_p0    <= '0;
                    wsel_p0   <= '0;
                    regwen_p0 <= 1'b0;
                    memren_p0 <= 1'b0;
                    memwen_p0 <= 1'b0;
                    halt_p0   <= 1'b0;
                end else begin
                    aluout_p0 <= aluout_in;
                    rtdata_p0 <= rtdata_in;
                    npc_p0    <= npc_in;
                    wsel_p0   <= wsel_in;
                    regwen_p0 <= regwen_in && !misalign;
                    memren_p0 <= memren_in;
                    memwen_p0 <= memwen_in;
                    halt_p0   <= halt_in;
                end
                load_p0  <= '0;
                fault_p0 <= misalign;
                state    <= go_req ? REQ : IDLE;
            end
        end
    end

    assign dmemREN      = (state == REQ) && memren_p0;
    assign dmemWEN      = (state == REQ) && memwen_p0;
    assign dmemaddr     = aluout_p0;
    assign dmemstore    = rtdata_p0;
    assign dmemload_out = load_p0;
    assign dmemaddr_out = aluout_p0;
    assign npc_out      = npc_p0;
    assign wsel_out     = wsel_p0;
    assign regwen_out   = regwen_p0;
    assign halt_out     = halt_p0;
    assign align_fault  = fault_p0;

endmodule

// File: tb/tb_pl_ex_mem.sv
// Directed bench for pl_ex_mem: load, store, flush-in-REQ, reset-in-REQ, alignment, halt.
module tb_pl_ex_mem;

    logic        CLK = 1'b0;
    logic        nRST, WEN, flush;
    logic [31:0] aluout_in, rtdata_in, npc_in, dmemload_in;
    logic [4:0]  wsel_in;
    logic        regwen_in, memren_in, memwen_in, halt_in, dhit;
    logic        dmemREN, dmemWEN, mem_busy, regwen_out, halt_out, align_fault;
    logic [31:0] dmemaddr, dmemstore, dmemload_out, dmemaddr_out, npc_out;
    logic [4:0]  wsel_out;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    pl_ex_mem #(.WORD_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .WEN(WEN), .flush(flush),
        .aluout_in(aluout_in), .rtdata_in(rtdata_in), .npc_in(npc_in),
        .wsel_in(wsel_in), .regwen_in(regwen_in), .memren_in(memren_in),
        .memwen_in(memwen_in), .halt_in(halt_in),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dhit(dhit), .dmemload_in(dmemload_in), .mem_busy(mem_busy),
        .dmemload_out(dmemload_out), .dmemaddr_out(dmemaddr_out), .npc_out(npc_out),
        .wsel_out(wsel_out), .regwen_out(regwen_out), .halt_out(halt_out),
        .align_fault(align_fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        WEN = 0; flush = 0; aluout_in = 0; rtdata_in = 0; npc_in = 0; wsel_in = 0;
        regwen_in = 0; memren_in = 0; memwen_in = 0; halt_in = 0;
    endtask

    initial begin
        nRST = 0; dhit = 0; dmemload_in = 0;
        idle_inputs();
        #3;
        check("rst_busy",  32'(mem_busy), 0);
        check("rst_ren",   32'(dmemREN), 0);
        check("rst_wen",   32'(dmemWEN), 0);
        check("rst_halt",  32'(halt_out), 0);
        check("rst_align", 32'(align_fault), 0);
        check("rst_state", 32'(dut.state), 0);
        @(negedge CLK); nRST = 1;
        cyc();

        // load with two miss cycles
        WEN = 1; memren_in = 1; aluout_in = 32'h100; regwen_in = 1; wsel_in = 5; npc_in = 32'h44;
        cyc();
        idle_inputs();
        check("ld_ren",   32'(dmemREN), 1);
        check("ld_addr",  dmemaddr, 32'h100);
        check("ld_busy1", 32'(mem_busy), 1);
        WEN = 1; aluout_in = 32'h999; regwen_in = 1;
        cyc();
        check("ld_busy2", 32'(mem_busy), 1);
        check("ld_hold",  dmemaddr, 32'h100);
        idle_inputs();
        dhit = 1; dmemload_in = 32'hDEAD_BEEF;
        #1;
        check("ld_hitfree", 32'(mem_busy), 0);
        cyc();
        dhit = 0;
        check("ld_data",  dmemload_out, 32'hDEAD_BEEF);
        check("ld_state", 32'(dut.state), 2);
        check("ld_ren0",  32'(dmemREN), 0);
        check("ld_regw",  32'(regwen_out), 1);
        check("ld_wsel",  32'(wsel_out), 5);
        check("ld_npc",   npc_out, 32'h44);
        check("ld_aout",  dmemaddr_out, 32'h100);

        // store with same-cycle hit
        WEN = 1; memwen_in = 1; aluout_in = 32'h200; rtdata_in = 32'h1234;
        cyc();
        idle_inputs();
        dhit = 1;
        #1;
        check("st_wen",   32'(dmemWEN), 1);
        check("st_data",  dmemstore, 32'h1234);
        check("st_busy",  32'(mem_busy), 0);
        check("st_ren",   32'(dmemREN), 0);
        cyc();
        dhit = 0;
        check("st_wen0",  32'(dmemWEN), 0);

        // flush arriving while the request is stalled
        WEN = 1; memren_in = 1; aluout_in = 32'h300; regwen_in = 1; wsel_in = 7;
        cyc();
        WEN = 1; flush = 1; memren_in = 0; aluout_in = 32'h400; regwen_in = 1; wsel_in = 9;
        cyc();
        check("fl_ren",   32'(dmemREN), 1);
        check("fl_addr",  dmemaddr, 32'h300);
        check("fl_wsel",  32'(wsel_out), 7);
        dhit = 1; dmemload_in = 32'h55;
        cyc();
        dhit = 0;
        idle_inputs();
        check("fl_regw",  32'(regwen_out), 0);
        check("fl_aout",  dmemaddr_out, 0);
        check("fl_state", 32'(dut.state), 0);
        check("fl_ren0",  32'(dmemREN), 0);

        // reset while a request is outstanding
        WEN = 1; memren_in = 1; aluout_in = 32'h500;
        cyc();
        idle_inputs();
        check("rr_ren",   32'(dmemREN), 1);
        #2 nRST = 0;
        #1;
        check("rr_ren0",  32'(dmemREN), 0);
        check("rr_busy",  32'(mem_busy), 0);
        @(negedge CLK); nRST = 1;
        cyc();
        cyc();
        check("rr_state", 32'(dut.state), 0);
        check("rr_noreq", 32'(dmemREN), 0);

        // misaligned load
        WEN = 1; memren_in = 1; aluout_in = 32'h102; regwen_in = 1;
        cyc();
        idle_inputs();
`ifdef PL_EX_MEM_ALIGN_CHECK_EN
        check("al_fault", 32'(align_fault), 1);
        check("al_ren",   32'(dmemREN), 0);
        check("al_regw",  32'(regwen_out), 0);
        WEN = 1; regwen_in = 1; aluout_in = 32'h8;
        cyc();
        idle_inputs();
        check("al_clear", 32'(align_fault), 0);
`else
        check("al_fault", 32'(align_fault), 0);
        check("al_ren",   32'(dmemREN), 1);
        check("al_addr",  dmemaddr, 32'h102);
        dhit = 1;
        cyc();
        dhit = 0;
        check("al_done",  32'(dut.state), 2);
`endif

        // halt is sticky and blocks later work
        WEN = 1; halt_in = 1; npc_in = 32'h70;
        cyc();
        idle_inputs();
        check("ht_halt",  32'(halt_out), 1);
        WEN = 1; memren_in = 1; aluout_in = 32'h600;
        cyc();
        check("ht_ren",   32'(dmemREN), 0);
        check("ht_aout",  dmemaddr_out, 0);
        cyc();
        idle_inputs();
        check("ht_ren2",  32'(dmemREN), 0);
        check("ht_stick", 32'(halt_out), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
